// File: rtl/mux_2x1.sv
// 32-bit two-input word multiplexer with a combinational output and a
// registered copy for pipeline-stage use.
module mux_2x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_reg
);

  // An unknown Select must not quietly fall through to A, so the default arm
  // drives all-X rather than relying on ?: bitwise merging.
  always_comb begin
    Q = 'x;
    case (Select)
      1'b0:    Q = A;
      1'b1:    Q = B;
      default: Q = 'x;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q_reg <= '0;
    end else begin
      Q_reg <= Q;
    end
  end

endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: directed scenarios plus randomized traffic,
// with a queue-based scoreboard for the registered output.
module tb_mux_2x1;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Select = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q;
  logic [W-1:0] Q_reg;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops   = 0;

  logic [W-1:0] expq[$];
  bit           model_live = 1'b0;

  mux_2x1 #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Select (Select),
    .A      (A),
    .B      (B),
    .Q      (Q),
    .Q_reg  (Q_reg)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    if (s == 1'b0) return a;
    return b;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string name);
    Select = s;
    A      = a;
    B      = b;
    #1;
    check(name, Q, pick(s, a, b));
  endtask

  // Reference model: Q_reg is undefined until the first reset edge; from then
  // on each edge yields either zero (reset) or the selected word.
  always @(posedge Clk) begin
    if (Reset) model_live = 1'b1;
    if (model_live) begin
      expq.push_back(Reset ? '0 : pick(Select, A, B));
      pushes++;
    end
  end

  always @(posedge Clk) begin
    logic [W-1:0] e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      pops++;
      check("q_reg_scoreboard", Q_reg, e);
    end
  end

  initial begin
    logic [W-1:0] qbefore;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           mode;

    // 1-3: purely combinational behaviour, no reset applied yet
    Select = 1'b0; A = 32'hA5A5A5A5; B = 32'h12345678;
    #10 check("t1_q_sel0", Q, 32'hA5A5A5A5);
    Select = 1'b1;
    #10 check("t2_q_sel1", Q, 32'h12345678);
    A = 32'h0;
    #1 check("t3_q_hold_b", Q, 32'h12345678);
    Select = 1'b0;
    #1 check("t3_q_no_clock", Q, 32'h00000000);

    // 4: reset clears Q_reg, Q keeps following inputs
    @(negedge Clk);
    Reset = 1'b1;
    drive(1'b0, 32'h11111111, 32'h22222222, "t4_q_in_reset");
    @(posedge Clk); #2;
    check("t4_q_reg_reset", Q_reg, '0);
    check("t4_q_during_reset", Q, 32'h11111111);
    @(negedge Clk);
    Reset = 1'b0;
    drive(1'b0, 32'hDEADBEEF, 32'h22222222, "t4_q_release");
    check("t4_q_reg_not_before", Q_reg, '0);
    @(posedge Clk); #2;
    check("t4_q_reg_load", Q_reg, 32'hDEADBEEF);

    // 5: toggling select, Q_reg lags Q by one cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      drive(i[0], 32'hFFFFFFFF, 32'h00000000, "t5_q_toggle");
      qbefore = (i[0] == 1'b0) ? 32'hFFFFFFFF : 32'h00000000;
      @(posedge Clk); #2;
      check("t5_q_reg_lag", Q_reg, qbefore);
    end

    // 6: reset mid-stream with B selected
    @(negedge Clk);
    Reset = 1'b1;
    drive(1'b1, 32'h0BADF00D, 32'h12345678, "t6_q_before_edge");
    @(posedge Clk); #2;
    check("t6_q_reg_reset", Q_reg, '0);
    check("t6_q_at_edge", Q, 32'h12345678);
    @(negedge Clk);
    Reset = 1'b0;
    #1 check("t6_q_after_release", Q, 32'h12345678);

    // Randomized traffic with all-ones / all-zeros corners mixed in
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      Reset = ($urandom_range(15) == 0);
      mode  = $urandom_range(3);
      case (mode)
        0:       begin ra = '1; rb = '0; end
        1:       begin ra = '0; rb = '1; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      drive(1'($urandom_range(1)), ra, rb, "rand_q");
    end

    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (expq.size() != 0 || pops != pushes || pops == 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pops %0d pushes %0d left %0d",
               pops, pushes, expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
